// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants and next-state helper
// for the parametrised Fibonacci LFSR.
package lfsr_pkg;

  localparam logic MODE_EDGE  = 1'b0;
  localparam logic MODE_LEVEL = 1'b1;

  // Primitive taps; bit i set feeds state bit i into feedback
  localparam logic [2:0]  TAPS_3  = 3'b101;
  localparam logic [3:0]  TAPS_4  = 4'b1001;
  localparam logic [4:0]  TAPS_5  = 5'b10010;
  localparam logic [5:0]  TAPS_6  = 6'b100001;
  localparam logic [6:0]  TAPS_7  = 7'b1000001;
  localparam logic [7:0]  TAPS_8  = 8'b10111000;
  localparam logic [8:0]  TAPS_9  = 9'b100010000;
  localparam logic [9:0]  TAPS_10 = 10'b1001000000;
  localparam logic [10:0] TAPS_11 = 11'b10100000000;
  localparam logic [11:0] TAPS_12 = 12'b100000101001;
  localparam logic [12:0] TAPS_13 = 13'b1000000001101;
  localparam logic [13:0] TAPS_14 = 14'b10000000010101;
  localparam logic [14:0] TAPS_15 = 15'b100000000000001;
  localparam logic [15:0] TAPS_16 = 16'b1000000000010110;

  function automatic logic [31:0] lfsr_next(
    input logic [31:0] s,
    input logic [31:0] t,
    input int unsigned w
  );
    logic [31:0] m;
    m = (32'h1 << w) - 32'h1;
    return {s[30:0], ^(s & t)} & m;
  endfunction

endpackage

// File: rtl/lfsr_step_ctrl.sv
// lfsr_step_ctrl: enable edge detector and mode mux
// producing the single-cycle step strobe.
module lfsr_step_ctrl
  import lfsr_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic mode,
  output logic step
);

  logic was_en;

  always_ff @(posedge clk) begin
    if (reset) was_en <= 1'b0;
    else       was_en <= enable;
  end

  always_comb begin
    step = 1'b0;
    unique case (mode)
      MODE_LEVEL: step = enable;
      default:    step = enable & ~was_en;
    endcase
  end

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci LFSR with seed load, zero-lockup
// recovery and on-line period measurement.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS = 7'b100_0001,
  parameter logic [WIDTH-1:0] INIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] out,
  output logic             bit_out,
  output logic             lockup,
  output logic             wrap,
  output logic [WIDTH-1:0] period
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] ldv;
  logic             step;
  logic             raw_zero;
  logic             sat;
  logic             hit;

  lfsr_step_ctrl u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .step   (step)
  );

  assign raw = WIDTH'(lfsr_next(32'(state), 32'(TAPS), WIDTH));
  assign raw_zero = (raw == '0);
  assign nxt = raw_zero ? INIT : raw;
  assign ldv = (seed == '0) ? INIT : seed;
  assign sat = &cnt;
  // saturated counter means the reference was lost: stop wrapping
  assign hit = (nxt == ref_q) && !sat;

  assign out = state;
  assign bit_out = state[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= INIT;
      ref_q  <= INIT;
      cnt    <= '0;
      period <= '0;
      lockup <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      lockup <= 1'b0;
      wrap   <= 1'b0;
      if (load) begin
        state  <= ldv;
        ref_q  <= ldv;
        cnt    <= '0;
        lockup <= (seed == '0);
      end else if (step) begin
        state  <= nxt;
        lockup <= raw_zero;
        if (hit) begin
          wrap   <= 1'b1;
          period <= cnt + 1'b1;
          cnt    <= '0;
        end else if (!sat) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: vector table, directed wrap/reset sequences
// and random run against a behavioural model.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       reset, enable, mode, load;
  logic [6:0] seed;
  logic [6:0] out, period, out2, period2;
  logic       bit_out, lockup, wrap;
  logic       bit_out2, lockup2, wrap2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lfsr_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .load(load), .seed(seed), .out(out), .bit_out(bit_out),
    .lockup(lockup), .wrap(wrap), .period(period)
  );

  // non-invertible taps: exercises zero collapse and saturation
  lfsr_gen #(.WIDTH(7), .TAPS(7'b0100001), .INIT(7'h05)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .load(load), .seed(seed), .out(out2), .bit_out(bit_out2),
    .lockup(lockup2), .wrap(wrap2), .period(period2)
  );

  typedef struct {
    logic [6:0] s, rf, per;
    int         cnt;
    bit         lock, wrap, was;
  } mdl_t;

  typedef struct {
    bit         rst, en, md, ld;
    logic [6:0] sd, eout;
    bit         elock, ewrap;
    logic [6:0] eper;
  } vec_t;

  mdl_t m1, m2;
  vec_t tbl[$];

  function automatic mdl_t mstep(mdl_t m, logic [6:0] taps,
                                 logic [6:0] init);
    mdl_t r;
    int   si, v;
    bit   go;
    r = m;
    r.lock = 0;
    r.wrap = 0;
    if (reset) begin
      r.s = init; r.rf = init; r.cnt = 0; r.per = 0; r.was = 0;
      return r;
    end
    go = mode ? enable : (enable && !m.was);
    r.was = enable;
    if (load) begin
      v = (seed == 0) ? int'(init) : int'(seed);
      r.lock = (seed == 0);
      r.s = 7'(v); r.rf = 7'(v); r.cnt = 0;
    end else if (go) begin
      si = int'(m.s);
      v = ((si * 2) % 128) + ($countones(m.s & taps) % 2);
      if (v == 0) begin
        v = int'(init);
        r.lock = 1;
      end
      r.s = 7'(v);
      if (v == int'(m.rf) && m.cnt < 127) begin
        r.wrap = 1; r.per = 7'(m.cnt + 1); r.cnt = 0;
      end else if (m.cnt < 127) begin
        r.cnt = m.cnt + 1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    m1 = mstep(m1, 7'b1000001, 7'h01);
    m2 = mstep(m2, 7'b0100001, 7'h05);
    @(posedge clk);
    #1;
    chk("m1.out", out, m1.s);
    chk("m1.bit_out", bit_out, m1.s[6]);
    chk("m1.lockup", lockup, m1.lock);
    chk("m1.wrap", wrap, m1.wrap);
    chk("m1.period", period, m1.per);
    chk("m2.out", out2, m2.s);
    chk("m2.bit_out", bit_out2, m2.s[6]);
    chk("m2.lockup", lockup2, m2.lock);
    chk("m2.wrap", wrap2, m2.wrap);
    chk("m2.period", period2, m2.per);
  endtask

  task automatic drive(input bit r, e, md, l, input logic [6:0] sd);
    reset = r; enable = e; mode = md; load = l; seed = sd;
  endtask

  task automatic add(input bit r, e, md, l, input logic [6:0] sd,
                     input logic [6:0] eo, input bit el, ew,
                     input logic [6:0] ep);
    vec_t v;
    v.rst = r; v.en = e; v.md = md; v.ld = l; v.sd = sd;
    v.eout = eo; v.elock = el; v.ewrap = ew; v.eper = ep;
    tbl.push_back(v);
  endtask

  initial begin
    int nw, wi;
    m1 = '{s: 0, rf: 0, per: 0, cnt: 0, lock: 0, wrap: 0, was: 0};
    m2 = m1;
    drive(1, 0, 0, 0, 0);

    add(1, 0, 1, 0, 0, 7'h01, 0, 0, 0);
    add(0, 1, 1, 0, 0, 7'h03, 0, 0, 0);
    add(0, 1, 1, 0, 0, 7'h07, 0, 0, 0);
    add(0, 1, 1, 0, 0, 7'h0F, 0, 0, 0);
    add(0, 1, 1, 0, 0, 7'h1F, 0, 0, 0);
    add(0, 1, 1, 0, 0, 7'h3F, 0, 0, 0);
    add(0, 1, 1, 0, 0, 7'h7F, 0, 0, 0);
    add(1, 0, 0, 0, 0, 7'h01, 0, 0, 0);
    add(0, 1, 0, 0, 0, 7'h03, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 7'h03, 0, 0, 0);
    for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 0, 7'h03, 0, 0, 0);
    add(0, 1, 0, 0, 0, 7'h07, 0, 0, 0);
    add(0, 0, 0, 1, 7'h00, 7'h01, 1, 0, 0);
    add(0, 0, 0, 0, 0, 7'h01, 0, 0, 0);
    add(0, 1, 0, 1, 7'h55, 7'h55, 0, 0, 0);
    add(0, 1, 0, 0, 0, 7'h55, 0, 0, 0);
    add(0, 1, 0, 0, 0, 7'h55, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].md, tbl[i].ld, tbl[i].sd);
      cyc();
      chk($sformatf("vec%0d.out", i), out, tbl[i].eout);
      chk($sformatf("vec%0d.bit", i), bit_out, tbl[i].eout[6]);
      chk($sformatf("vec%0d.lock", i), lockup, tbl[i].elock);
      chk($sformatf("vec%0d.wrap", i), wrap, tbl[i].ewrap);
      chk($sformatf("vec%0d.per", i), period, tbl[i].eper);
    end

    drive(1, 0, 1, 0, 0);
    cyc();
    for (int pass = 0; pass < 2; pass++) begin
      drive(0, 1, 1, 0, 0);
      nw = 0; wi = 0;
      for (int i = 1; i <= 127; i++) begin
        cyc();
        if (wrap) begin nw++; wi = i; end
      end
      chk($sformatf("wrap%0d.count", pass), nw, 1);
      chk($sformatf("wrap%0d.cycle", pass), wi, 127);
      chk($sformatf("wrap%0d.out", pass), out, 7'h01);
      chk($sformatf("wrap%0d.period", pass), period, 127);
    end

    for (int i = 0; i < 10; i++) cyc();
    drive(0, 1, 1, 1, 7'h00);
    cyc();
    chk("load0.out", out, 7'h01);
    chk("load0.lockup", lockup, 1);
    chk("load0.period", period, 127);
    drive(0, 1, 1, 0, 0);
    cyc();
    chk("load0.lock_pulse", lockup, 0);
    nw = 0; wi = 0;
    for (int i = 2; i <= 127; i++) begin
      cyc();
      if (wrap) begin nw++; wi = i; end
    end
    chk("load0.wrap_cycle", wi, 127);
    chk("load0.wrap_count", nw, 1);

    for (int i = 0; i < 40; i++) cyc();
    drive(1, 1, 0, 0, 0);
    cyc();
    chk("rst.out", out, 7'h01);
    chk("rst.period", period, 0);
    chk("rst.wrap", wrap, 0);
    drive(0, 1, 0, 0, 0);
    cyc();
    chk("rst.first_step", out, 7'h03);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 299) == 0,
            $urandom_range(0, 9) < 8,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 63) == 0,
            7'($urandom_range(0, 127)));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
